// File: rtl/config_chain_loader.sv
// Serial configuration chain loader: streams config words bit-serially into
// the tile chain head and captures the chain tail for readback.
module config_chain_loader #(
  parameter int WORD_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] chain_length,
  input  logic [WORD_WIDTH-1:0]  word_data,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   cfg_data,
  output logic                   cfg_enable,
  input  logic                   cfg_return,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bits_shifted,
  output logic [WORD_WIDTH-1:0]  readback_data
);

  localparam int WCW = $clog2(WORD_WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] length_q;
  logic [WORD_WIDTH-1:0]  buffer;
  logic [WCW-1:0]         word_cnt;
  logic [COUNT_WIDTH-1:0] shift_next;
  logic                   accept;

  assign shift_next = bits_shifted + 1'b1;
  assign accept     = word_valid & word_ready;

  // Abort blocks the handshake so no word is lost in the abort cycle
  assign word_ready = (state == FETCH) & ~abort;
  assign cfg_enable = (state == SHIFT);
  assign cfg_data   = cfg_enable & buffer[0];
  assign busy       = (state == FETCH) | (state == SHIFT);
  assign done       = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      length_q      <= '0;
      buffer        <= '0;
      word_cnt      <= '0;
      bits_shifted  <= '0;
      readback_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            length_q      <= chain_length;
            bits_shifted  <= '0;
            readback_data <= '0;
            state <= (chain_length != '0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            buffer   <= word_data;
            word_cnt <= WCW'(WORD_WIDTH);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          buffer        <= buffer >> 1;
          bits_shifted  <= shift_next;
          readback_data <= {cfg_return, readback_data[WORD_WIDTH-1:1]};
          word_cnt      <= word_cnt - 1'b1;
          // Reaching the chain length beats word exhaustion
          if (abort) begin
            state <= IDLE;
          end else if (shift_next == length_q) begin
            state <= DONE;
          end else if (word_cnt == WCW'(1)) begin
            state <= FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench for config_chain_loader with a 24-bit chain model
// on the tail; expected bit stream and done records come from word lists.
module tb_config_chain_loader;

  localparam int WW = 32;
  localparam int CW = 16;
  localparam int CH = 24;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] chain_length;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          cfg_data;
  logic          cfg_enable;
  logic          cfg_return;
  logic          busy;
  logic          done;
  logic [CW-1:0] bits_shifted;
  logic [WW-1:0] readback_data;

  config_chain_loader #(
    .WORD_WIDTH (WW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .chain_length (chain_length),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .cfg_data     (cfg_data),
    .cfg_enable   (cfg_enable),
    .cfg_return   (cfg_return),
    .busy         (busy),
    .done         (done),
    .bits_shifted (bits_shifted),
    .readback_data(readback_data)
  );

  always #5 clock = ~clock;

  // Chain model: bits enter at bit 0 and emerge from bit CH-1
  logic [CH-1:0] chain;
  logic          preload_req;
  logic [CH-1:0] preload_val;

  always @(posedge clock) begin
    if (preload_req) chain <= preload_val;
    else if (cfg_enable) chain <= {chain[CH-2:0], cfg_data};
  end
  assign cfg_return = chain[CH-1];

  typedef struct {
    logic [CW-1:0] bs;
    logic [WW-1:0] rb;
  } done_t;

  int    checks   = 0;
  int    failures = 0;
  bit    exp_bits[$];
  done_t exp_done[$];
  logic [WW-1:0] words[$];
  bit    exp_b;
  done_t exp_d;

  int n_en, n_wr, n_fetch, n_done, first_en, done_cyc;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every enabled chain cycle and every done pulse is scored
  always @(negedge clock) begin
    if (cfg_enable) begin
      if (exp_bits.size() == 0) begin
        check("unexpected_shift", 64'd1, 64'd0);
      end else begin
        exp_b = exp_bits.pop_front();
        check("cfg_data", {63'd0, cfg_data}, {63'd0, exp_b});
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_d = exp_done.pop_front();
        check("done_bits_shifted", {48'd0, bits_shifted}, {48'd0, exp_d.bs});
        check("done_readback", {32'd0, readback_data}, {32'd0, exp_d.rb});
      end
    end
  end

  task automatic fill_words(input int n);
    words.delete();
    repeat (n) words.push_back($urandom);
  endtask

  // cut>0: abort (or reset when cut_reset) during the cut-th shift cycle
  task automatic do_load(input int L, input int stall, input int cut,
                         input bit cut_reset, input logic [CH-1:0] pre,
                         input bit extra_start);
    int nw, wi, stall_left, c, k_end, lo;
    bit acc, fin, e;
    done_t d;
    logic [WW-1:0] rb;
    nw = (L + WW - 1) / WW;
    while (words.size() < nw) words.push_back($urandom);
    @(posedge clock); #1;
    preload_req = 1'b1;
    preload_val = pre;
    @(posedge clock); #1;
    preload_req = 1'b0;
    k_end = (cut > 0) ? cut : L;
    for (int k = 0; k < k_end; k++) exp_bits.push_back(words[k / WW][k % WW]);
    if (cut == 0) begin
      rb = '0;
      lo = (L > WW) ? L - WW : 0;
      for (int k = lo; k < L; k++) begin
        e = (k < CH) ? pre[CH-1-k] : words[(k - CH) / WW][(k - CH) % WW];
        rb[WW - L + k] = e;
      end
      d.bs = CW'(L);
      d.rb = rb;
      exp_done.push_back(d);
    end
    n_en = 0; n_wr = 0; n_fetch = 0; n_done = 0;
    first_en = -1; done_cyc = -1;
    c = 0; wi = 0; stall_left = stall; fin = 1'b0; acc = 1'b0;
    start = 1'b1;
    chain_length = CW'(L);
    word_valid = 1'b0;
    abort = 1'b0;
    @(negedge clock);
    if (word_ready) n_wr++;
    while (!fin && c < 3000) begin
      @(posedge clock); #1;
      c++;
      start = extra_start && busy && ($urandom_range(0, 3) == 0);
      chain_length = CW'($urandom);
      if (acc) wi++;
      abort = 1'b0;
      reset = 1'b0;
      if (cut > 0 && cfg_enable && n_en == cut - 1) begin
        if (cut_reset) reset = 1'b1;
        else abort = 1'b1;
      end
      if (wi >= nw) begin
        word_valid = 1'b0;
        word_data = $urandom;
      end else if (wi == 1 && stall_left > 0 && busy && !cfg_enable) begin
        word_valid = 1'b0;
        stall_left--;
      end else begin
        word_valid = 1'b1;
        word_data = words[wi];
      end
      @(negedge clock);
      acc = word_valid && word_ready;
      if (cfg_enable) begin
        n_en++;
        if (first_en < 0) first_en = c;
      end
      if (word_ready) n_wr++;
      if (busy && !cfg_enable) n_fetch++;
      if (done) begin
        n_done++;
        done_cyc = c;
        fin = 1'b1;
      end
      if (abort || reset) fin = 1'b1;
    end
    check("load_timeout", {63'd0, fin}, 64'd1);
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    word_valid = 1'b0;
    @(negedge clock);
  endtask

  int L;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
    word_data = '0;
    chain_length = '0;
    preload_req = 1'b0;
    preload_val = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_word_ready", {63'd0, word_ready}, 64'd0);
    check("rst_cfg_enable", {63'd0, cfg_enable}, 64'd0);
    check("rst_cfg_data", {63'd0, cfg_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_bits", {48'd0, bits_shifted}, 64'd0);
    check("rst_readback", {32'd0, readback_data}, 64'd0);

    // One word, 24 bits, valid held
    words.delete();
    words.push_back(32'h00A5C3F0);
    do_load(24, 0, 0, 1'b0, 24'h5A5A5A, 1'b0);
    check("t1_first_en", first_en, 2);
    check("t1_n_en", n_en, 24);
    check("t1_done_cyc", done_cyc, 26);
    check("t1_n_wr", n_wr, 1);
    check("t1_bits", {48'd0, bits_shifted}, 64'd24);
    check("t1_busy", {63'd0, busy}, 64'd0);

    // Three words with a 5-cycle stall before the second
    fill_words(3);
    do_load(72, 5, 0, 1'b0, CH'($urandom), 1'b0);
    check("t2_n_en", n_en, 72);
    check("t2_n_fetch", n_fetch, 8);
    check("t2_n_done", n_done, 1);

    // Zero length
    words.delete();
    do_load(0, 0, 0, 1'b0, CH'($urandom), 1'b0);
    check("t3_n_wr", n_wr, 0);
    check("t3_n_en", n_en, 0);
    check("t3_done_cyc", done_cyc, 1);
    check("t3_bits", {48'd0, bits_shifted}, 64'd0);

    // Preloaded chain of ones flushed by zeros
    words.delete();
    words.push_back(32'h0);
    do_load(24, 0, 0, 1'b0, 24'hFFFFFF, 1'b0);
    check("t4_readback_hi", {40'd0, readback_data[31:8]}, 64'hFFFFFF);
    check("t4_chain", {40'd0, chain}, 64'd0);

    // Abort in the 10th shift cycle, then a normal load
    fill_words(3);
    do_load(72, 0, 10, 1'b0, CH'($urandom), 1'b0);
    check("t5_cfg_enable", {63'd0, cfg_enable}, 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_bits", {48'd0, bits_shifted}, 64'd10);
    check("t5_n_done", n_done, 0);
    check("t5_exp_empty", exp_bits.size(), 0);
    fill_words(2);
    do_load(40, 1, 0, 1'b0, CH'($urandom), 1'b0);
    check("t5_reload_bits", {48'd0, bits_shifted}, 64'd40);

    // Reset mid-shift with starts pulsed while busy
    fill_words(2);
    do_load(50, 0, 6, 1'b1, CH'($urandom), 1'b1);
    check("t6_word_ready", {63'd0, word_ready}, 64'd0);
    check("t6_cfg_enable", {63'd0, cfg_enable}, 64'd0);
    check("t6_cfg_data", {63'd0, cfg_data}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_done", {63'd0, done}, 64'd0);
    check("t6_bits", {48'd0, bits_shifted}, 64'd0);
    check("t6_readback", {32'd0, readback_data}, 64'd0);
    repeat (8) @(negedge clock);
    check("t6_idle_busy", {63'd0, busy}, 64'd0);

    // Randomized loads, including word-boundary lengths
    for (int i = 0; i < 20; i++) begin
      case (i % 5)
        0: L = 1;
        1: L = 32 * $urandom_range(1, 4);
        2: L = 32 * $urandom_range(1, 4) + 1;
        default: L = $urandom_range(2, 160);
      endcase
      fill_words((L + WW - 1) / WW);
      do_load(L, $urandom_range(0, 3), 0, 1'b0, CH'($urandom), 1'b1);
      check("rnd_bits", {48'd0, bits_shifted}, L);
      check("rnd_n_en", n_en, L);
      check("rnd_busy", {63'd0, busy}, 64'd0);
    end

    repeat (4) @(negedge clock);
    check("end_bits_empty", exp_bits.size(), 0);
    check("end_done_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
